// File: rtl/key_event_gen.sv
// key_event_gen: turns Keyboard_Decoder make/break strobes into one-cycle key
// pulses, with typematic auto-repeat on the four direction keys.
module key_event_gen #(
    parameter logic [8:0] UP_CODE       = 9'h01D,
    parameter logic [8:0] LEFT_CODE     = 9'h01C,
    parameter logic [8:0] DOWN_CODE     = 9'h01B,
    parameter logic [8:0] RIGHT_CODE    = 9'h023,
    parameter logic [8:0] ENTER_CODE    = 9'h05A,
    parameter int         REPEAT_DELAY  = 50_000_000,
    parameter int         REPEAT_PERIOD = 10_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [8:0]   last_change,
    input  logic [511:0] key_down,
    input  logic         enable,
    output logic         key_U,
    output logic         key_D,
    output logic         key_L,
    output logic         key_R,
    output logic         key_C,
    output logic [4:0]   held,
    output logic         repeat_active
);

    localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
    localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      trk_q, trk_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      pulse_q, pulse_d;
    logic            repeat_active_d;

    logic            is_dir;
    logic [1:0]      dir_code;
    logic            code_down;
    logic            dir_make;
    logic            dir_break;
    logic            enter_make;

    // Direction codes map to trk values 0..3 = U, D, L, R, matching the
    // bit order of the {U,D,L,R,C} pulse vector so 5'b10000 >> code is one-hot.
    always_comb begin
        is_dir   = 1'b1;
        dir_code = 2'd0;
        case (last_change)
            UP_CODE:    dir_code = 2'd0;
            DOWN_CODE:  dir_code = 2'd1;
            LEFT_CODE:  dir_code = 2'd2;
            RIGHT_CODE: dir_code = 2'd3;
            default:    is_dir   = 1'b0;
        endcase
    end

    assign code_down  = key_down[last_change];
    assign dir_make   = key_valid && is_dir && code_down;
    assign dir_break  = key_valid && is_dir && !code_down;
    assign enter_make = key_valid && (last_change == ENTER_CODE) && code_down;

    // A direction make always wins: it pulses, retargets and restarts DELAY.
    // Enter only borrows the pulse slot; the counter keeps its cadence.
    always_comb begin
        state_d = state_q;
        trk_d   = trk_q;
        cnt_d   = cnt_q;
        pulse_d = 5'b00000;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (dir_make) begin
            pulse_d = 5'b10000 >> dir_code;
            trk_d   = dir_code;
            cnt_d   = DELAY_LOAD;
            state_d = ST_DELAY;
        end else if (dir_break && (state_q != ST_IDLE) && (dir_code == trk_q)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            if (enter_make) begin
                pulse_d = 5'b00001;
            end
            if (state_q != ST_IDLE) begin
                if (cnt_q == '0) begin
                    if (!enter_make) begin
                        pulse_d = 5'b10000 >> trk_q;
                    end
                    cnt_d   = PERIOD_LOAD;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    // Qualified with the next state so a break drops the flag on the same
    // edge that leaves REPEAT, while entry still shows one cycle late.
    assign repeat_active_d = (state_q == ST_REPEAT) && (state_d == ST_REPEAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            trk_q         <= 2'd0;
            cnt_q         <= '0;
            pulse_q       <= 5'b00000;
            held          <= 5'b00000;
            repeat_active <= 1'b0;
        end else begin
            state_q       <= state_d;
            trk_q         <= trk_d;
            cnt_q         <= cnt_d;
            pulse_q       <= pulse_d;
            repeat_active <= repeat_active_d;
            if (key_valid) begin
                held <= {key_down[UP_CODE], key_down[DOWN_CODE], key_down[LEFT_CODE],
                         key_down[RIGHT_CODE], key_down[ENTER_CODE]};
            end
        end
    end

    assign key_U = pulse_q[4];
    assign key_D = pulse_q[3];
    assign key_L = pulse_q[2];
    assign key_R = pulse_q[1];
    assign key_C = pulse_q[0];

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: directed checks of press pulses, auto-repeat timing,
// retarget collisions, Enter/unrelated codes, enable gating and async reset.
module tb_key_event_gen;

    localparam logic [8:0] W_CODE     = 9'h01D;
    localparam logic [8:0] A_CODE     = 9'h01C;
    localparam logic [8:0] S_CODE     = 9'h01B;
    localparam logic [8:0] D_CODE     = 9'h023;
    localparam logic [8:0] ENTER_CODE = 9'h05A;
    localparam logic [8:0] SPACE_CODE = 9'h029;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_valid = 1'b0;
    logic [8:0]   last_change = 9'd0;
    logic [511:0] key_down = '0;
    logic         enable = 1'b1;
    logic         key_U, key_D, key_L, key_R, key_C;
    logic [4:0]   held;
    logic         repeat_active;
    logic [4:0]   pulses;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    key_event_gen #(
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .last_change   (last_change),
        .key_down      (key_down),
        .enable        (enable),
        .key_U         (key_U),
        .key_D         (key_D),
        .key_L         (key_L),
        .key_R         (key_R),
        .key_C         (key_C),
        .held          (held),
        .repeat_active (repeat_active)
    );

    assign pulses = {key_U, key_D, key_L, key_R, key_C};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One key_valid strobe sampled at the next edge; returns 1 ns after it.
    task automatic apply_stimulus(input logic [8:0] code, input logic down);
        key_down[code] = down;
        last_change    = code;
        key_valid      = 1'b1;
        tick();
        key_valid      = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [4:0] observed,
                                input logic [4:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        // Power-on reset
        rst = 1'b0;
        repeat (3) tick();
        check_output("reset_pulses", pulses, 5'b00000);
        check_output("reset_held", held, 5'b00000);
        check_output("reset_active", {4'b0, repeat_active}, 5'b00000);
        rst = 1'b1;
        tick();

        // Single press / release of W
        apply_stimulus(W_CODE, 1'b1);
        check_output("press_U_pulse", pulses, 5'b10000);
        check_output("press_U_held", held, 5'b10000);
        tick();
        check_output("press_U_one_cycle", pulses, 5'b00000);
        check_output("press_U_held_t2", held, 5'b10000);
        tick();
        check_output("press_U_held_t3", held, 5'b10000);
        apply_stimulus(W_CODE, 1'b0);
        check_output("release_U_pulse", pulses, 5'b00000);
        check_output("release_U_held", held, 5'b00000);
        for (int c = 5; c <= 30; c++) begin
            tick();
            check_output("release_U_quiet", pulses, 5'b00000);
        end

        // Auto-repeat of S, break coinciding with a due repeat
        apply_stimulus(S_CODE, 1'b1);
        check_output("rep_D_make", pulses, 5'b01000);
        for (int c = 2; c <= 40; c++) begin
            tick();
            check_output("rep_D_pulse", pulses,
                         (c == 21 || c == 26 || c == 31 || c == 36) ? 5'b01000 : 5'b00000);
            check_output("rep_D_active", {4'b0, repeat_active}, (c >= 22) ? 5'd1 : 5'd0);
        end
        apply_stimulus(S_CODE, 1'b0);
        check_output("break_vs_expiry", pulses, 5'b00000);
        check_output("break_active_low", {4'b0, repeat_active}, 5'b00000);
        for (int c = 42; c <= 50; c++) begin
            tick();
            check_output("after_break_quiet", pulses, 5'b00000);
        end

        // Retarget: D make lands on A's first expiry
        apply_stimulus(A_CODE, 1'b1);
        check_output("retarget_L_make", pulses, 5'b00100);
        for (int c = 2; c <= 20; c++) begin
            tick();
            check_output("retarget_L_wait", pulses, 5'b00000);
        end
        apply_stimulus(D_CODE, 1'b1);
        check_output("collide_R_only", pulses, 5'b00010);
        for (int c = 22; c <= 41; c++) begin
            tick();
            check_output("retarget_R_sched", pulses, (c == 41) ? 5'b00010 : 5'b00000);
        end
        apply_stimulus(D_CODE, 1'b0);
        check_output("release_R", pulses, 5'b00000);
        apply_stimulus(A_CODE, 1'b0);
        check_output("release_L", pulses, 5'b00000);

        // Enter and space while W repeats
        apply_stimulus(W_CODE, 1'b1);
        check_output("enter_U_make", pulses, 5'b10000);
        for (int c = 2; c <= 37; c++) begin
            if (c == 28) apply_stimulus(ENTER_CODE, 1'b1);
            else if (c == 33) apply_stimulus(SPACE_CODE, 1'b1);
            else tick();
            check_output("enter_cadence", pulses,
                         (c == 21 || c == 26 || c == 31 || c == 36) ? 5'b10000 :
                         (c == 28) ? 5'b00001 : 5'b00000);
        end
        check_output("space_held", held, 5'b10001);
        apply_stimulus(ENTER_CODE, 1'b0);
        check_output("release_enter", pulses, 5'b00000);
        apply_stimulus(W_CODE, 1'b0);
        check_output("release_W", pulses, 5'b00000);
        key_down[SPACE_CODE] = 1'b0;

        // Back-to-back strobes
        apply_stimulus(A_CODE, 1'b1);
        check_output("b2b_first", pulses, 5'b00100);
        apply_stimulus(S_CODE, 1'b1);
        check_output("b2b_second", pulses, 5'b01000);
        apply_stimulus(S_CODE, 1'b0);
        check_output("b2b_release_S", pulses, 5'b00000);
        apply_stimulus(A_CODE, 1'b0);
        for (int c = 0; c < 25; c++) begin
            tick();
            check_output("b2b_quiet", pulses, 5'b00000);
        end

        // Async reset in the middle of a repeat
        apply_stimulus(W_CODE, 1'b1);
        for (int c = 2; c <= 26; c++) tick();
        check_output("pre_reset_pulse", pulses, 5'b10000);
        check_output("pre_reset_active", {4'b0, repeat_active}, 5'd1);
        #2 rst = 1'b0;
        #1;
        check_output("async_reset_pulses", pulses, 5'b00000);
        check_output("async_reset_held", held, 5'b00000);
        check_output("async_reset_active", {4'b0, repeat_active}, 5'd0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            check_output("post_reset_quiet", pulses, 5'b00000);
        end
        check_output("post_reset_active", {4'b0, repeat_active}, 5'd0);
        apply_stimulus(W_CODE, 1'b0);

        // Enable gating
        enable = 1'b0;
        apply_stimulus(W_CODE, 1'b1);
        check_output("disabled_pulse", pulses, 5'b00000);
        check_output("disabled_held", held, 5'b10000);
        tick();
        enable = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            check_output("enable_rise_quiet", pulses, 5'b00000);
        end
        check_output("enable_rise_idle", {4'b0, repeat_active}, 5'd0);
        apply_stimulus(W_CODE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
